mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline MEM stage directly downstream of the EX/MEM register: word-addressed data memory with configurable access latency, plus the MEM/WB pipeline register feeding write-back and the forwarding unit.
- Asserts stall_o back to the hazard unit while a multi-cycle load/store is in flight.
- Inserts write-back bubbles until the access completes.

Parameters:
- DEPTH, 256: data memory size in 32-bit words (power of two).
- ADDR_W, 8: word-index width, equal to log2(DEPTH).
- LATENCY, 2: extra stall cycles per memory op. 0 means a single-cycle access.

Ports:
- clk_i  in  1  clock. All state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- WB_i  in  2  [1]=MemToReg, [0]=RegWrite, from EX/MEM.
- ALUOut_i  in  32  ALU result, also the byte address.
- mux7_i  in  32  store data (forwarded RT).
- mux3_i  in  5  destination register.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- stall_o  out  1  combinational. High means upstream must hold the EX/MEM contents.
- WB_o  out  2  registered copy of WB, or 2'b00 for a bubble.
- ALUOut_o  out  32  registered ALU result.
- rdata_o  out  32  registered load data. 0 for non-loads.
- mux3_o  out  5  registered destination register.
- misalign_o  out  1  registered. High for one cycle with the completing op if ALUOut[1:0]!=0.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State=IDLE, cnt=0, captured-request registers=0.
  - All outputs 0.
  - Memory contents are not reset. Any in-flight op is aborted and no write is committed.
- Word index: ALUOut[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH. Bits [1:0] are ignored for the access but flagged on misalign_o.
- States: IDLE, BUSY. Counter cnt is ceil(log2(LATENCY+1)) bits wide, minimum 1.
- IDLE, no mem op (MemRead_i=MemWrite_i=0):
  - stall_o=0.
  - At the edge, the MEM/WB register loads WB_i, ALUOut_i and mux3_i, with rdata_o=0 and misalign_o=0.
  - One-cycle latency, the same as a plain pipeline register.
- IDLE, mem op with LATENCY=0:
  - Completes at that edge.
  - A store writes mux7_i.
  - A load registers mem[index] into rdata_o.
  - The MEM/WB register loads as above. stall_o=0.
- IDLE, mem op with LATENCY>0:
  - stall_o=1.
  - At the edge, capture WB, ALUOut, mux7, mux3, read and write into internal registers, then go to BUSY with cnt=1.
  - The MEM/WB register loads a bubble: WB_o=0, other outputs 0.
- BUSY, cnt<LATENCY:
  - stall_o=1.
  - cnt increments.
  - The MEM/WB register loads a bubble.
- BUSY, cnt==LATENCY:
  - stall_o=0.
  - At the edge, perform the captured access, load the MEM/WB register from the captured request plus rdata, and return to IDLE.
  - The captured copy is used, not the live inputs. Inputs changing during BUSY have no effect.
- Op cost: each mem op occupies LATENCY+1 cycles. stall_o is high for exactly the first LATENCY of them.
- A new op presented in the cycle after completion starts normally. There is no dead cycle.
- MemRead and MemWrite both high: the store is performed, rdata_o=0, and WB_o is forced to 0.
- Loads from never-written locations return X. The bench must initialise memory before reading it.
- A store followed immediately by a load to the same index returns the newly stored data.
- Forwarding: WB_o[0], mux3_o and ALUOut_o are valid only outside bubbles. Bubbles always have WB_o[0]=0.

Test Plan:
- LATENCY=0, ALU op with WB_i=01, ALUOut_i=0x1234, mux3_i=5 -> next cycle WB_o=01, ALUOut_o=0x1234, mux3_o=5, rdata_o=0, stall_o never high.
- LATENCY=2, store 0xDEADBEEF to address 0x10, then load from 0x10 with WB_i=11, mux3_i=8 -> each op holds stall_o=1 for exactly 2 cycles with WB_o=0 bubbles. The load completes with rdata_o=0xDEADBEEF, WB_o=11, mux3_o=8.
- LATENCY=2, with DEPTH=256 giving an index wrap at 0x400: store 0xA5A5A5A5 to address 0x404, then load from 0x004 -> rdata_o=0xA5A5A5A5. Load from 0x006 -> same data with misalign_o=1 for one cycle.
- LATENCY=2, load issued and inputs changed to garbage during BUSY -> completion uses the captured address and destination register; garbage never appears on the outputs.
- LATENCY=3, store issued, rst_i pulled low at BUSY cnt=2, then released and the same address loaded -> the old value is returned. All outputs are 0 and stall_o=0 immediately on rst_i low.
- MemRead_i=MemWrite_i=1 with data 0x55 to address 0x20 -> memory at 0x20 becomes 0x55, the completing output has WB_o=0 and rdata_o=0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Bus between the EX/MEM register and the MEM stage: request fields in,
// MEM/WB register contents and the hazard-unit stall out.
interface mem_wb_stage_if;
    logic [1:0]  WB_i;
    logic [31:0] ALUOut_i;
    logic [31:0] mux7_i;
    logic [4:0]  mux3_i;
    logic        MemRead_i;
    logic        MemWrite_i;

    logic        stall_o;
    logic [1:0]  WB_o;
    logic [31:0] ALUOut_o;
    logic [31:0] rdata_o;
    logic [4:0]  mux3_o;
    logic        misalign_o;

    modport master (
        output WB_i, ALUOut_i, mux7_i, mux3_i, MemRead_i, MemWrite_i,
        input  stall_o, WB_o, ALUOut_o, rdata_o, mux3_o, misalign_o
    );

    modport slave (
        input  WB_i, ALUOut_i, mux7_i, mux3_i, MemRead_i, MemWrite_i,
        output stall_o, WB_o, ALUOut_o, rdata_o, mux3_o, misalign_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Pipeline MEM stage: word-addressed data memory with a fixed extra access
// latency, stall generation towards the hazard unit, and the MEM/WB register.
module mem_wb_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_wb_stage_if.slave  bus
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam bit MULTI = (LATENCY > 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request captured when a multi-cycle op starts; BUSY works only from this copy.
    logic [1:0]  cap_wb;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_rd;
    logic        cap_read;
    logic        cap_write;

    logic [31:0] mem [DEPTH];

    logic              live_op;
    logic              capture;
    logic              done;
    logic [1:0]        sel_wb;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [4:0]        sel_rd;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] idx;
    logic              do_write;
    logic              do_read;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        live_op   = bus.MemRead_i | bus.MemWrite_i;
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        done      = 1'b0;
        sel_wb    = bus.WB_i;
        sel_addr  = bus.ALUOut_i;
        sel_wdata = bus.mux7_i;
        sel_rd    = bus.mux3_i;
        sel_read  = bus.MemRead_i;
        sel_write = bus.MemWrite_i;

        case (state_q)
            IDLE: begin
                done = !live_op || !MULTI;
                if (live_op && MULTI) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                    capture = 1'b1;
                end
            end
            BUSY: begin
                sel_wb    = cap_wb;
                sel_addr  = cap_addr;
                sel_wdata = cap_wdata;
                sel_rd    = cap_rd;
                sel_read  = cap_read;
                sel_write = cap_write;
                if (cnt_q == LAT_CNT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx      = sel_addr[ADDR_W+1:2];
    assign do_write = rst_i & done & sel_write;
    // A simultaneous read+write is treated as a store only.
    assign do_read  = done & sel_read & ~sel_write;

    // Held low during reset so the hazard unit never sees a stale request.
    assign bus.stall_o = rst_i & ~done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cap_wb    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rd    <= '0;
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
        end else if (capture) begin
            cap_wb    <= bus.WB_i;
            cap_addr  <= bus.ALUOut_i;
            cap_wdata <= bus.mux7_i;
            cap_rd    <= bus.mux3_i;
            cap_read  <= bus.MemRead_i;
            cap_write <= bus.MemWrite_i;
        end
    end

    // NOTE: the data array has no reset; clearing it would force a flop-based
    // memory and software never relies on its power-up contents.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[idx] <= sel_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.WB_o       <= '0;
            bus.ALUOut_o   <= '0;
            bus.rdata_o    <= '0;
            bus.mux3_o     <= '0;
            bus.misalign_o <= 1'b0;
        end else if (done) begin
            bus.WB_o       <= (sel_read && sel_write) ? 2'b00 : sel_wb;
            bus.ALUOut_o   <= sel_addr;
            bus.rdata_o    <= do_read ? mem[idx] : 32'h0;
            bus.mux3_o     <= sel_rd;
            bus.misalign_o <= (sel_read | sel_write) & (|sel_addr[1:0]);
        end else begin
            // Bubble: WB_o[0]=0 keeps forwarding and write-back inert.
            bus.WB_o       <= '0;
            bus.ALUOut_o   <= '0;
            bus.rdata_o    <= '0;
            bus.mux3_o     <= '0;
            bus.misalign_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: three instances (LATENCY 0, 2, 3)
// driven with directed and random ops, checked against a transaction model.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic        wr_en;
    } req_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
    } out_t;

    typedef struct {
        int   stalls;
        bit   bubble_bad;
        bit   done;
        out_t fin;
    } obs_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    req_t       drv  [3];
    out_t       outs [3];
    logic       stl  [3];
    int         checks = 0;
    int         errors = 0;
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_wb_stage_if bus ();
        assign bus.WB_i       = drv[g].wb;
        assign bus.ALUOut_i   = drv[g].addr;
        assign bus.mux7_i     = drv[g].wdata;
        assign bus.mux3_i     = drv[g].rd;
        assign bus.MemRead_i  = drv[g].rd_en;
        assign bus.MemWrite_i = drv[g].wr_en;
        assign stl[g]  = bus.stall_o;
        assign outs[g] = {bus.WB_o, bus.ALUOut_o, bus.rdata_o, bus.mux3_o, bus.misalign_o};

        mem_wb_stage #(
            .DEPTH(DEPTH), .ADDR_W(8),
            .LATENCY(g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) dut (
            .clk_i(clk),
            .rst_i(rst_v[g]),
            .bus  (bus)
        );
    end

    function automatic int lat_of(int w);
        return (w == 0) ? 0 : ((w == 1) ? 2 : 3);
    endfunction

    // Architectural view: one op in, one MEM/WB result out, memory as a map.
    function automatic out_t model_op(int w, req_t r);
        out_t e;
        int   key;
        key     = w * DEPTH + int'((r.addr >> 2) % DEPTH);
        e.wb    = (r.rd_en && r.wr_en) ? 2'b00 : r.wb;
        e.alu   = r.addr;
        e.rd    = r.rd;
        e.mis   = (r.rd_en || r.wr_en) && (r.addr % 4 != 0);
        e.rdata = 32'h0;
        if (r.wr_en) model_mem[key] = r.wdata;
        else if (r.rd_en) e.rdata = model_mem.exists(key) ? model_mem[key] : 'x;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wb    = 2'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.rd    = 5'($urandom);
        r.rd_en = 1'($urandom);
        r.wr_en = 1'($urandom);
        return r;
    endfunction

    task automatic set_idle(int w);
        drv[w] = '0;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic do_op(int w, req_t r, bit garbage, output obs_t o);
        logic s;
        o.stalls = 0; o.bubble_bad = 0; o.done = 0; o.fin = '0;
        drv[w] = r;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            s = stl[w];
            @(posedge clk);
            #1;
            if (s !== 1'b1) begin
                o.fin  = outs[w];
                o.done = 1;
                break;
            end
            o.stalls++;
            if (outs[w] !== '0) o.bubble_bad = 1;
            if (garbage) drv[w] = rand_req();
        end
    endtask

    task automatic test_reset();
        for (int w = 0; w < 3; w++) drv[w] = '0;
        #2 rst_v = 3'b000;
        #10;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({stl[w], outs[w]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got stall=%b out=%h want all zero", w, stl[w], outs[w]);
            end
        end
        @(posedge clk);
        #1 rst_v = 3'b111;
    endtask

    task automatic test_alu_l0();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.wb = 2'b01; r.addr = 32'h1234; r.rd = 5'd5;
        do_op(0, r, 0, o);
        void'(model_op(0, r));
        want = '{wb: 2'b01, alu: 32'h1234, rdata: 32'h0, rd: 5'd5, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 0 || o.fin !== want) begin
            errors++;
            $display("FAIL alu_l0 stalls=%0d out=%h want stalls=0 out=%h", o.stalls, o.fin, want);
        end
        r = '0; r.addr = 32'h40; r.wdata = 32'hCAFE0001; r.wr_en = 1;
        do_op(0, r, 0, o);
        void'(model_op(0, r));
        r = '0; r.wb = 2'b11; r.addr = 32'h40; r.rd = 5'd7; r.rd_en = 1;
        do_op(0, r, 0, o);
        void'(model_op(0, r));
        want = '{wb: 2'b11, alu: 32'h40, rdata: 32'hCAFE0001, rd: 5'd7, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 0 || o.fin !== want) begin
            errors++;
            $display("FAIL load_l0 stalls=%0d out=%h want stalls=0 out=%h", o.stalls, o.fin, want);
        end
        set_idle(0);
    endtask

    task automatic test_store_load();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.addr = 32'h10; r.wdata = 32'hDEADBEEF; r.wr_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        want = '{wb: 2'b00, alu: 32'h10, rdata: 32'h0, rd: 5'd0, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 2 || o.bubble_bad || o.fin !== want) begin
            errors++;
            $display("FAIL store_l2 stalls=%0d bub_bad=%0b out=%h want stalls=2 out=%h",
                     o.stalls, o.bubble_bad, o.fin, want);
        end
        r = '0; r.wb = 2'b11; r.addr = 32'h10; r.rd = 5'd8; r.rd_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        want = '{wb: 2'b11, alu: 32'h10, rdata: 32'hDEADBEEF, rd: 5'd8, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 2 || o.bubble_bad || o.fin !== want) begin
            errors++;
            $display("FAIL load_l2 stalls=%0d bub_bad=%0b out=%h want stalls=2 out=%h",
                     o.stalls, o.bubble_bad, o.fin, want);
        end
        set_idle(1);
    endtask

    task automatic test_wrap_misalign();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.addr = 32'h404; r.wdata = 32'hA5A5A5A5; r.wr_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        r = '0; r.wb = 2'b11; r.addr = 32'h004; r.rd = 5'd3; r.rd_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        want = '{wb: 2'b11, alu: 32'h004, rdata: 32'hA5A5A5A5, rd: 5'd3, mis: 1'b0};
        checks++;
        if (!o.done || o.fin !== want) begin
            errors++;
            $display("FAIL wrap_load out=%h want %h", o.fin, want);
        end
        r.addr = 32'h006;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        want = '{wb: 2'b11, alu: 32'h006, rdata: 32'hA5A5A5A5, rd: 5'd3, mis: 1'b1};
        checks++;
        if (!o.done || o.fin !== want) begin
            errors++;
            $display("FAIL misalign_load out=%h want %h", o.fin, want);
        end
        set_idle(1);
        @(posedge clk);
        #1;
        checks++;
        if (outs[1].mis !== 1'b0) begin
            errors++;
            $display("FAIL misalign_one_cycle misalign=%b want 0", outs[1].mis);
        end
    endtask

    task automatic test_busy_garbage();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.addr = 32'h30; r.wdata = 32'h0BADF00D; r.wr_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        r = '0; r.wb = 2'b11; r.addr = 32'h30; r.rd = 5'd12; r.rd_en = 1;
        do_op(1, r, 1, o);
        void'(model_op(1, r));
        set_idle(1);
        want = '{wb: 2'b11, alu: 32'h30, rdata: 32'h0BADF00D, rd: 5'd12, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 2 || o.bubble_bad || o.fin !== want) begin
            errors++;
            $display("FAIL busy_garbage stalls=%0d bub_bad=%0b out=%h want stalls=2 out=%h",
                     o.stalls, o.bubble_bad, o.fin, want);
        end
    endtask

    task automatic test_reset_midop();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.addr = 32'h80; r.wdata = 32'h11112222; r.wr_en = 1;
        do_op(2, r, 0, o);
        void'(model_op(2, r));
        checks++;
        if (!o.done || o.stalls != 3) begin
            errors++;
            $display("FAIL store_l3_stalls got=%0d want 3", o.stalls);
        end
        // Second store is aborted at cnt=2 and must never reach memory.
        r.wdata = 32'h99999999;
        drv[2] = r;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stl[2] !== 1'b1) begin
            errors++;
            $display("FAIL busy_stall_l3 stall=%b want 1", stl[2]);
        end
        rst_v[2] = 1'b0;
        #1;
        checks++;
        if ({stl[2], outs[2]} !== '0) begin
            errors++;
            $display("FAIL reset_midop stall=%b out=%h want all zero", stl[2], outs[2]);
        end
        set_idle(2);
        @(posedge clk);
        #1 rst_v[2] = 1'b1;
        r = '0; r.wb = 2'b11; r.addr = 32'h80; r.rd = 5'd9; r.rd_en = 1;
        do_op(2, r, 0, o);
        void'(model_op(2, r));
        set_idle(2);
        want = '{wb: 2'b11, alu: 32'h80, rdata: 32'h11112222, rd: 5'd9, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 3 || o.fin !== want) begin
            errors++;
            $display("FAIL load_after_abort stalls=%0d out=%h want stalls=3 out=%h",
                     o.stalls, o.fin, want);
        end
    endtask

    task automatic test_read_write_both();
        req_t r;
        obs_t o;
        out_t want;
        r = '0; r.wb = 2'b11; r.addr = 32'h20; r.wdata = 32'h55; r.rd = 5'd4;
        r.rd_en = 1; r.wr_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        want = '{wb: 2'b00, alu: 32'h20, rdata: 32'h0, rd: 5'd4, mis: 1'b0};
        checks++;
        if (!o.done || o.stalls != 2 || o.fin !== want) begin
            errors++;
            $display("FAIL rw_both stalls=%0d out=%h want stalls=2 out=%h", o.stalls, o.fin, want);
        end
        r = '0; r.wb = 2'b11; r.addr = 32'h20; r.rd = 5'd4; r.rd_en = 1;
        do_op(1, r, 0, o);
        void'(model_op(1, r));
        set_idle(1);
        checks++;
        if (o.fin.rdata !== 32'h55) begin
            errors++;
            $display("FAIL rw_both_mem got=%h want 00000055", o.fin.rdata);
        end
    endtask

    // Back-to-back random ops: each op is driven on the cycle after the last completed.
    task automatic test_random(int w, int n);
        logic [7:0] idx [8];
        req_t r;
        obs_t o;
        out_t e;
        int   kind;
        int   want_stalls;
        for (int i = 0; i < 8; i++) idx[i] = 8'($urandom);
        for (int k = 0; k < n + 8; k++) begin
            kind = (k < 8) ? 1 : int'($urandom_range(0, 3));
            r = '0;
            r.wb    = 2'($urandom);
            r.rd    = 5'($urandom);
            r.wdata = $urandom;
            r.addr  = $urandom;
            if (kind != 0) r.addr[9:2] = idx[(k < 8) ? k : int'($urandom_range(0, 7))];
            r.rd_en = (kind == 2) || (kind == 3);
            r.wr_en = (kind == 1) || (kind == 3);
            want_stalls = (r.rd_en || r.wr_en) ? lat_of(w) : 0;
            do_op(w, r, (lat_of(w) > 0) && ($urandom_range(0, 1) == 1), o);
            e = model_op(w, r);
            checks++;
            if (!o.done || o.stalls != want_stalls || o.bubble_bad) begin
                errors++;
                $display("FAIL rand_timing dut=%0d op=%0d stalls=%0d bub_bad=%0b done=%0b want stalls=%0d",
                         w, k, o.stalls, o.bubble_bad, o.done, want_stalls);
            end
            checks++;
            if (o.fin !== e) begin
                errors++;
                $display("FAIL rand_out dut=%0d op=%0d got=%h want=%h", w, k, o.fin, e);
            end
        end
        set_idle(w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_l0();
        test_store_load();
        test_wrap_misalign();
        test_busy_garbage();
        test_reset_midop();
        test_read_write_both();
        test_random(0, 40);
        test_random(1, 40);
        test_random(2, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
